// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame arbiter: arbiter state encoding,
// default frame width and a constant-evaluable clog2 for channel index width.
package spi_pkg;

  localparam int DEFAULT_DATA_W = 24;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_frame_slot.sv
// One listener channel: interrupt edge detect, frame capture register, pending flag
// and sticky overrun flag (overrun logic present only with SPI_ARB_OVERRUN_EN).
module spi_frame_slot
  import spi_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              irq,
  input  logic [DATA_W-1:0] data,
  input  logic              load,
  input  logic              overrun_clr,
  output logic [DATA_W-1:0] hold,
  output logic              pend,
  output logic              overrun
);

  logic irq_q;
  logic rise;

  assign rise = irq & ~irq_q;

  // A capture in the same cycle as a load keeps pend set: the output takes the
  // old hold value while the new frame replaces it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_q <= 1'b1;
      hold  <= '0;
      pend  <= 1'b0;
    end else begin
      irq_q <= irq;
      if (rise) begin
        hold <= data;
        pend <= 1'b1;
      end else if (load) begin
        pend <= 1'b0;
      end
    end
  end

`ifdef SPI_ARB_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else begin
      overrun <= (rise & pend & ~load) | (overrun & ~overrun_clr);
    end
  end
`else
  logic unused_clr;
  assign unused_clr = overrun_clr;
  assign overrun    = 1'b0;
`endif

endmodule

// File: rtl/spi_frame_arbiter.sv
// Round-robin arbiter delivering captured SPI frames to one valid/ready port.
// Optional overrun flags are built when SPI_ARB_OVERRUN_EN is defined.
// Handshake: a frame transfers on a cycle where out_valid & out_ready; out_valid,
// out_data and out_ch stay stable until that cycle and out_ready is ignored when idle.
module spi_frame_arbiter
  import spi_pkg::*;
#(
  parameter  int N_CH   = 4,
  parameter  int DATA_W = DEFAULT_DATA_W,
  localparam int CH_W   = clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        irq_in,
  input  logic [N_CH*DATA_W-1:0] data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [CH_W-1:0]        out_ch,
  output logic [N_CH-1:0]        overrun,
  input  logic [N_CH-1:0]        overrun_clr,
  output logic                   dbg_state
);

  logic [DATA_W-1:0] hold [N_CH];
  logic [N_CH-1:0]   pend;
  logic [N_CH-1:0]   load;

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    spi_frame_slot #(.DATA_W(DATA_W)) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .irq         (irq_in[k]),
      .data        (data_in[k*DATA_W +: DATA_W]),
      .load        (load[k]),
      .overrun_clr (overrun_clr[k]),
      .hold        (hold[k]),
      .pend        (pend[k]),
      .overrun     (overrun[k])
    );
  end

  arb_state_t        state_q, state_d;
  logic [CH_W-1:0]   last, last_d;
  logic              valid_d;
  logic [DATA_W-1:0] data_d;
  logic [CH_W-1:0]   ch_d;
  logic [CH_W-1:0]   base;
  logic [CH_W-1:0]   sel;
  logic              sel_found;
  logic              handshake;

  assign handshake = out_valid & out_ready;
  assign dbg_state = state_q;

  // While offering, a reselect happens only on acceptance, at which point last
  // becomes out_ch; searching from out_ch here avoids waiting for last to update.
  assign base = (state_q == OFFER) ? out_ch : last;

  always_comb begin
    sel_found = 1'b0;
    sel       = '0;
    for (int i = 1; i <= N_CH; i++) begin
      if (!sel_found && pend[CH_W'((int'(base) + i) % N_CH)]) begin
        sel_found = 1'b1;
        sel       = CH_W'((int'(base) + i) % N_CH);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = out_valid;
    data_d  = out_data;
    ch_d    = out_ch;
    last_d  = last;
    load    = '0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          load[sel] = 1'b1;
          valid_d   = 1'b1;
          data_d    = hold[sel];
          ch_d      = sel;
          state_d   = OFFER;
        end
      end
      OFFER: begin
        if (handshake) begin
          last_d = out_ch;
          if (sel_found) begin
            load[sel] = 1'b1;
            data_d    = hold[sel];
            ch_d      = sel;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      last      <= CH_W'(N_CH - 1);
    end else begin
      state_q   <= state_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_ch    <= ch_d;
      last      <= last_d;
    end
  end

endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Bench for spi_frame_arbiter: directed scenarios plus a randomized run, all
// compared against a frame-level reference model of the arbitration rules.
module tb_spi_frame_arbiter;
  import spi_pkg::*;

  localparam int N  = 4;
  localparam int W  = 24;
  localparam int CW = 2;
`ifdef SPI_ARB_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   irq_in;
  logic [N*W-1:0] data_in;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [CW-1:0]  out_ch;
  logic [N-1:0]   overrun;
  logic [N-1:0]   overrun_clr;
  logic           dbg_state;

  int checks = 0;
  int errors = 0;
  logic [CW+W-1:0] exp_q[$];

  // reference model state
  logic [N-1:0] m_irq_q, m_pend, m_ovr;
  logic [W-1:0] m_hold [N];
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_ch, m_last;

  always #5 clk = ~clk;

  spi_frame_arbiter #(.N_CH(N), .DATA_W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq_in      (irq_in),
    .data_in     (data_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ch      (out_ch),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .dbg_state   (dbg_state)
  );

  task automatic model_reset();
    m_irq_q = '1;
    m_pend  = '0;
    m_ovr   = '0;
    for (int c = 0; c < N; c++) m_hold[c] = '0;
    m_valid = 1'b0;
    m_data  = '0;
    m_ch    = 0;
    m_last  = N - 1;
  endtask

  // One clock of the arbitration rules, using the inputs about to be sampled.
  task automatic model_clock();
    int pick;
    bit free;
    bit rise;
    bit set;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pick = -1;
    free = !m_valid || out_ready;
    if (m_valid && out_ready) m_last = m_ch;
    if (free) begin
      for (int i = 1; i <= N; i++) begin
        int c = (m_last + i) % N;
        if (pick < 0 && m_pend[c]) pick = c;
      end
    end
    if (pick >= 0) begin
      m_valid = 1'b1;
      m_data  = m_hold[pick];
      m_ch    = pick;
    end else if (free) begin
      m_valid = 1'b0;
    end
    for (int c = 0; c < N; c++) begin
      rise = irq_in[c] && !m_irq_q[c];
      set  = OVR_EN && rise && m_pend[c] && (pick != c);
      m_ovr[c] = set || (m_ovr[c] && !overrun_clr[c]);
      if (rise) begin
        m_pend[c] = 1'b1;
        m_hold[c] = data_in[c*W +: W];
      end else if (pick == c) begin
        m_pend[c] = 1'b0;
      end
      m_irq_q[c] = irq_in[c];
    end
  endtask

  task automatic step();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int c, input logic [W-1:0] v);
    data_in[c*W +: W] = v;
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    irq_in      = '0;
    overrun_clr = '0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; irq_in = '0; data_in = '0; out_ready = 1'b0; overrun_clr = '0;
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h exp 0", out_data); end
    checks++; if (out_ch !== '0) begin errors++; $display("FAIL reset_ch: got %0d exp 0", out_ch); end
    checks++; if (overrun !== '0) begin errors++; $display("FAIL reset_overrun: got %b exp 0", overrun); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b exp 0", dbg_state); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_frame();
    out_ready = 1'b1;
    irq_in[2] = 1'b1;
    set_data(2, 24'hA1B2C3);
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b exp 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b exp 1", out_valid); end
    checks++; if (out_data !== 24'hA1B2C3) begin errors++; $display("FAIL single_data: got %h exp a1b2c3", out_data); end
    checks++; if (out_ch !== 2'd2) begin errors++; $display("FAIL single_ch: got %0d exp 2", out_ch); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle: got %b exp 0", out_valid); end
  endtask

  task automatic rr_burst(input int first);
    irq_in = '0;
    step();
    for (int k = 0; k < N; k++) set_data(k, 24'h100000 + k);
    for (int j = 0; j < N; j++) begin
      int c = (first + j) % N;
      exp_q.push_back({CW'(c), W'(24'h100000 + c)});
    end
    irq_in = '1;
    step();
    step();
    for (int j = 0; j < N; j++) begin
      logic [CW+W-1:0] e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || {out_ch, out_data} !== e)
        begin errors++; $display("FAIL rr_order[%0d]: got v=%b ch=%0d d=%h exp ch=%0d d=%h", j, out_valid, out_ch, out_data, e[CW+W-1:W], e[W-1:0]); end
      step();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b exp 0", out_valid); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    out_ready = 1'b1;
    rr_burst(0);
    irq_in = '0;
    step();
    irq_in[1] = 1'b1;
    set_data(1, 24'h1AAAAA);
    step();
    step();
    checks++; if (out_ch !== 2'd1 || out_data !== 24'h1AAAAA) begin errors++; $display("FAIL rr_prime: got ch=%0d d=%h exp ch=1 d=1aaaaa", out_ch, out_data); end
    step();
    rr_burst(2);
  endtask

  task automatic test_backpressure();
    int hs;
    out_ready = 1'b0;
    irq_in = '0;
    step();
    irq_in[3] = 1'b1;
    set_data(3, 24'hC0FFEE);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 24'hC0FFEE)
        begin errors++; $display("FAIL bp_stable[%0d]: got v=%b ch=%0d d=%h exp v=1 ch=3 d=c0ffee", i, out_valid, out_ch, out_data); end
      step();
    end
    out_ready = 1'b1;
    hs = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid && out_ready) hs++;
      step();
    end
    checks++; if (hs !== 1) begin errors++; $display("FAIL bp_handshakes: got %0d exp 1", hs); end
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    irq_in = '0;
    step();
    irq_in[1] = 1'b1; set_data(1, 24'h111111);
    step();
    step();
    irq_in[1] = 1'b0; step();
    irq_in[1] = 1'b1; set_data(1, 24'h222222); step();
    irq_in[1] = 1'b0; step();
    irq_in[1] = 1'b1; set_data(1, 24'h333333); step();
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 24'h111111)
      begin errors++; $display("FAIL ovr_offer_held: got v=%b ch=%0d d=%h exp v=1 ch=1 d=111111", out_valid, out_ch, out_data); end
    checks++; if (overrun !== (OVR_EN ? 4'b0010 : 4'b0000))
      begin errors++; $display("FAIL ovr_flag: got %b exp %b", overrun, (OVR_EN ? 4'b0010 : 4'b0000)); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 24'h333333)
      begin errors++; $display("FAIL ovr_newest: got v=%b ch=%0d d=%h exp v=1 ch=1 d=333333", out_valid, out_ch, out_data); end
    step();
    overrun_clr = 4'b0010;
    step();
    overrun_clr = '0;
    checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL ovr_clear: got %b exp 0000", overrun); end
  endtask

  task automatic test_reset_corner();
    irq_in = 4'b0001;
    set_data(0, 24'h0BAD00);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rc_held_irq[%0d]: got %b exp 0", i, out_valid); end
    end
    out_ready = 1'b0;
    irq_in = '0;
    step();
    irq_in[0] = 1'b1;
    step();
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rc_offer: got %b exp 1", out_valid); end
    rst_n = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0)
      begin errors++; $display("FAIL rc_mid_reset: got v=%b ch=%0d d=%h exp all 0", out_valid, out_ch, out_data); end
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rc_after[%0d]: got %b exp 0", i, out_valid); end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 2) == 0) irq_in[c] = ~irq_in[c];
        set_data(c, W'($urandom));
      end
      out_ready   = ($urandom_range(0, 3) != 0);
      overrun_clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      step();
      checks++;
      if (out_valid !== m_valid || out_data !== m_data || out_ch !== CW'(m_ch) || overrun !== m_ovr || dbg_state !== m_valid)
        begin errors++; $display("FAIL random[%0d]: got v=%b ch=%0d d=%h ovr=%b st=%b exp v=%b ch=%0d d=%h ovr=%b", n, out_valid, out_ch, out_data, overrun, dbg_state, m_valid, m_ch, m_data, m_ovr); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_frame();
    test_round_robin();
    test_backpressure();
    test_overrun();
    test_reset_corner();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
